// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I-subset control FSM.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the ALU
// function code, operand selects and the register/PC/memory strobes.
//
// Memory handshake: mem_req is held high, with adr_src and mem_we stable,
// until a cycle in which mem_ready is also high. That cycle completes the
// transfer, and the FSM leaves the waiting state on the following edge.
// mem_ready is ignored in every cycle where mem_req is low.
module multicycle_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        is_zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [2:0]  alu_control,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
      S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_HALT
   } state_t;

   // Registered Moore portion of the control word.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] res_src;
      logic [2:0] alu;
   } ctrl_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_SLL  = 3'b011;
   localparam logic [2:0] ALU_SRL  = 3'b100;
   localparam logic [2:0] ALU_AND  = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_SLTU = 3'b111;

   state_t     state;
   state_t     state_nxt;
   ctrl_t      ctrl;
   logic [2:0] funct3;
   logic       branch_take;
   logic       unused_fields;

   assign funct3        = instr[14:12];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // ALU function for an R/I arithmetic instruction; only R-type can select sub.
   function automatic logic [2:0] alu_op(input logic [31:0] ins, input logic is_r);
      logic [2:0] op;
      case (ins[14:12])
         3'b000:  op = (is_r && ins[30]) ? ALU_SUB : ALU_ADD;
         3'b100:  op = ALU_XOR;
         3'b001:  op = ALU_SLL;
         3'b101:  op = ALU_SRL;
         3'b111:  op = ALU_AND;
         3'b110:  op = ALU_OR;
         3'b011:  op = ALU_SLTU;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Legal funct3/funct7 combinations. No slt/slti; no arithmetic shifts.
   function automatic logic op_legal(input logic [31:0] ins, input logic is_r);
      logic [6:0] f7;
      logic       ok;
      f7 = ins[31:25];
      case (ins[14:12])
         3'b010:         ok = 1'b0;
         3'b001, 3'b101: ok = (f7 == 7'b0000000);
         3'b000:         ok = !is_r || (f7 == 7'b0000000) || (f7 == 7'b0100000);
         default:        ok = !is_r || (f7 == 7'b0000000);
      endcase
      return ok;
   endfunction

   // Next-state rule for every state.
   function automatic state_t next_state(input state_t s, input logic [31:0] ins,
                                         input logic mr);
      state_t n;
      case (s)
         S_FETCH:     n = mr ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (ins[6:0])
               OP_R:              n = op_legal(ins, 1'b1) ? S_EXEC_R : S_HALT;
               OP_I:              n = op_legal(ins, 1'b0) ? S_EXEC_I : S_HALT;
               OP_LOAD, OP_STORE: n = S_MEM_ADDR;
               OP_BRANCH:         n = S_BRANCH;
               OP_JAL:            n = S_JAL;
               default:           n = S_HALT;
            endcase
         end
         S_EXEC_R, S_EXEC_I, S_JAL: n = S_ALU_WB;
         S_ALU_WB, S_MEM_WB:        n = S_FETCH;
         S_MEM_ADDR: begin
            if (ins[14:12] != 3'b010)    n = S_HALT;
            else if (ins[6:0] == OP_LOAD) n = S_MEM_READ;
            else                          n = S_MEM_WRITE;
         end
         S_MEM_READ:  n = mr ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: n = mr ? S_FETCH : S_MEM_WRITE;
         S_BRANCH:    n = (ins[14:13] == 2'b00) ? S_FETCH : S_HALT;
         S_HALT:      n = S_HALT;
         default:     n = S_FETCH;
      endcase
      return n;
   endfunction

   // Moore control word for a state. It is loaded on the edge that enters that state.
   function automatic ctrl_t moore_ctrl(input state_t s, input logic [31:0] ins);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:     begin c.mem_req = 1'b1; c.src_b = 2'b10; c.res_src = 2'b10; end
         S_DECODE:    begin c.src_a = 2'b01; c.src_b = 2'b01; end
         S_EXEC_R:    begin c.src_a = 2'b10; c.alu = alu_op(ins, 1'b1); end
         S_EXEC_I:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu = alu_op(ins, 1'b0); end
         S_ALU_WB:    c.reg_write = 1'b1;
         S_MEM_ADDR:  begin c.src_a = 2'b10; c.src_b = 2'b01; end
         S_MEM_READ:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
         S_MEM_WB:    begin c.res_src = 2'b01; c.reg_write = 1'b1; end
         S_MEM_WRITE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
         S_BRANCH:    begin c.src_a = 2'b10; c.alu = ALU_SUB; end
         S_JAL:       begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
         default:     c = '0;
      endcase
      return c;
   endfunction

   // Next state from current state, instruction and memory handshake.
   always_comb begin
      state_nxt = S_FETCH;
      state_nxt = next_state(state, instr, mem_ready);
   end

   // State register with registered Moore outputs and the sticky illegal flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         ctrl    <= moore_ctrl(S_FETCH, instr);
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         ctrl    <= moore_ctrl(state_nxt, instr);
         illegal <= (state_nxt == S_HALT);
      end
   end

   assign branch_take = (state == S_BRANCH) &&
                        (((funct3 == 3'b000) && is_zero) || ((funct3 == 3'b001) && !is_zero));

   // Strobes are forced low while reset is held, whatever state is registered.
   assign mem_req     = ctrl.mem_req & ~reset;
   assign mem_we      = ctrl.mem_we & ~reset;
   assign reg_write   = ctrl.reg_write & ~reset;
   assign ir_write    = (state == S_FETCH) & mem_ready & ~reset;
   assign pc_write    = (ctrl.pc_write | ((state == S_FETCH) & mem_ready) | branch_take) & ~reset;
   assign adr_src     = ctrl.adr_src;
   assign alu_src_a   = ctrl.src_a;
   assign alu_src_b   = ctrl.src_b;
   assign result_src  = ctrl.res_src;
   assign alu_control = ctrl.alu;

endmodule
